// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// Latency: none (package only).
// Backpressure: none (package only).
package debounce_pkg;

   // Default build configuration
   localparam int DEF_N_CH       = 4;
   localparam int DEF_STABLE_CYC = 5;
   localparam int DEF_HOLD_CYC   = 1000;

   // Constant ceil(log2(value)), never less than 1 so every counter has at least one bit
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_canal.sv
// Single button channel: 2-FF synchroniser, stability filter, press/release pulses, sticky flag, optional hold counter.
// Latency: level and pulses change STABLE_CYC+2 cycles after btn_i settles; all outputs registered.
// Backpressure: none; push flag is held until ack_i (set wins over ack). Long press built with PULSADORES_DEBOUNCE_LONGPRESS_EN.
module debounce_canal
   import debounce_pkg::*;
#(
   parameter int STABLE_CYC = DEF_STABLE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   input  logic ack_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic flag_o,
   output logic long_o
);

   localparam int            CW      = clog2(STABLE_CYC);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic          level_q,   level_d;
   logic          press_q,   press_d;
   logic          release_q, release_d;
   logic          flag_q,    flag_d;

   // Two-stage synchroniser for the asynchronous pin
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Stability filter: the level follows only after STABLE_CYC consecutive disagreeing samples
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;
      // A release on the same edge as ack keeps the flag set
      if (release_d) begin
         flag_d = 1'b1;
      end else if (ack_i) begin
         flag_d = 1'b0;
      end else begin
         flag_d = flag_q;
      end
   end

   // Filter state, edge pulses and sticky flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         flag_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         flag_q    <= flag_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign flag_o    = flag_q;

`ifdef PULSADORES_DEBOUNCE_LONGPRESS_EN
   localparam int            HW       = clog2(HOLD_CYC + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

   logic [HW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Hold counter saturates at HOLD_CYC so the long pulse fires once per press
   always_comb begin
      if (!level_q) begin
         hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
         hold_d = hold_q + 1'b1;
      end else begin
         hold_d = hold_q;
      end
      long_d = (hold_q != HOLD_MAX) && (hold_d == HOLD_MAX);
   end

   // Hold counter and long-press pulse registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_o = long_q;
`else
   // No hold counter in this build; HOLD_CYC stays referenced so both builds share one parameter list
   assign long_o = (HOLD_CYC < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: rtl/pulsadores_debounce.sv
// N_CH independent push-button conditioners (level, press/release pulses, sticky push flag, long press).
// Latency: STABLE_CYC+2 cycles from a settled pin to level/pulse change; no combinational input-to-output path.
// Backpressure: none; push_flag holds until ack. Long press enabled by PULSADORES_DEBOUNCE_LONGPRESS_EN.
module pulsadores_debounce
   import debounce_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int STABLE_CYC = DEF_STABLE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic            clk,
   input  logic            listo_rst,
   input  logic [N_CH-1:0] btn_in,
   input  logic [N_CH-1:0] ack,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] push_flag,
   output logic [N_CH-1:0] long_press
);

   // One fully independent conditioner per button
   for (genvar g = 0; g < N_CH; g++) begin : g_canal
      debounce_canal #(
         .STABLE_CYC (STABLE_CYC),
         .HOLD_CYC   (HOLD_CYC)
      ) u_canal (
         .clk_i     (clk),
         .rst_i     (listo_rst),
         .btn_i     (btn_in[g]),
         .ack_i     (ack[g]),
         .level_o   (btn_level[g]),
         .press_o   (press_pulse[g]),
         .release_o (release_pulse[g]),
         .flag_o    (push_flag[g]),
         .long_o    (long_press[g])
      );
   end

endmodule
